// File: rtl/nibble_descrambler.sv
// Framed nibble descrambler: XORs each accepted 4-bit nibble with a 7-bit additive LFSR keystream (x^7+x^6+1).
// Optional frame check enabled by defining DESCR_PARITY_CHK_EN (adds par_ok/par_err ports).
module nibble_descrambler #(
    parameter logic [6:0] SEED_DEFAULT = 7'h7F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] seed,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_last,
    output logic       busy
`ifdef DESCR_PARITY_CHK_EN
    ,
    output logic       par_ok,
    output logic       par_err
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] lfsr;
    logic [6:0] lfsr_next;
    logic [3:0] key;
    logic [3:0] plain;
    logic       accept;

    // Handshake: a nibble transfers on a cycle where in_valid && in_ready; out_data/out_last
    // stay stable while out_valid && !out_ready. start blocks acceptance in its own cycle.
    assign accept = in_valid && in_ready;
    assign plain  = in_data ^ key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = RUN;
        end else if (state == RUN && accept && in_last) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy     = (state == RUN);
        in_ready = (state == RUN) && !start && (!out_valid || out_ready);
    end

    // Four LFSR steps per nibble; the first feedback bit becomes key[3].
    always_comb begin
        logic [6:0] s;
        logic       fb;
        s   = lfsr;
        fb  = 1'b0;
        key = 4'h0;
        for (int i = 3; i >= 0; i--) begin
            fb     = s[6] ^ s[5];
            key[i] = fb;
            s      = {s[5:0], fb};
        end
        lfsr_next = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_DEFAULT;
        end else if (start) begin
            lfsr <= (seed == 7'h00) ? SEED_DEFAULT : seed;
        end else if (accept) begin
            lfsr <= lfsr_next;
        end
    end

    // Single output register; a restart leaves any pending nibble in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 4'h0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= plain;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DESCR_PARITY_CHK_EN
    logic [3:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= 4'h0;
            par_ok  <= 1'b0;
            par_err <= 1'b0;
        end else begin
            if (start) begin
                acc <= 4'h0;
            end else if (accept && !in_last) begin
                acc <= acc ^ plain;
            end
            par_ok  <= accept && in_last && (plain == acc);
            par_err <= accept && in_last && (plain != acc);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_descrambler.sv
// Directed bench for nibble_descrambler; parity checks compile in when DESCR_PARITY_CHK_EN is defined.
module tb_nibble_descrambler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] seed;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
`ifdef DESCR_PARITY_CHK_EN
    logic       par_ok;
    logic       par_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    nibble_descrambler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .seed     (seed),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
`ifdef DESCR_PARITY_CHK_EN
        ,
        .par_ok   (par_ok),
        .par_err  (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        seed      = 7'h00;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [6:0] s);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one nibble, waits (bounded) for in_ready, returns on the negedge after the accept.
    task automatic push(input logic [3:0] d, input logic l, input string tag);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_accept: in_ready got %b want 1 (timeout)", tag, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        seed      = 7'h00;
        in_valid  = 1'b1;
        in_data   = 4'hA;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 4'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        n_checks++;
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
`ifdef DESCR_PARITY_CHK_EN
        n_checks++;
        if ({par_ok, par_err} !== 2'b00) begin n_fail++; $display("FAIL rst_par: got %b want 00", {par_ok, par_err}); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        // In IDLE with no start, a valid nibble must not be taken.
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
        in_valid = 1'b0;
    endtask

    // Seed 7F keystream nibbles are 0,2,0: inputs 5,5,last gives 5,7,last.
    task automatic run_frame(input logic [6:0] s, input logic [3:0] last_in, input string tag);
        logic [3:0] exp_d;
        exp_q = {4'h5, 4'h7, last_in};
        out_ready = 1'b1;
        pulse_start(s);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_rise: got %b want 1", tag, busy); end
        for (int i = 0; i < 3; i++) begin
            push((i == 2) ? last_in : 4'h5, (i == 2), tag);
            exp_d = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d) begin
                n_fail++;
                $display("FAIL %s_d%0d: got v=%b d=%h want v=1 d=%h", tag, i, out_valid, out_data, exp_d);
            end
            n_checks++;
            if (out_last !== (i == 2)) begin
                n_fail++;
                $display("FAIL %s_last%0d: got %b want %b", tag, i, out_last, (i == 2));
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_fall: got %b want 0", tag, busy); end
`ifdef DESCR_PARITY_CHK_EN
        // Accumulated 5^7 = 2, so last 2 is ok and anything else is an error.
        n_checks++;
        if (par_ok !== (last_in == 4'h2) || par_err !== (last_in != 4'h2)) begin
            n_fail++;
            $display("FAIL %s_par: got ok=%b err=%b want ok=%b err=%b", tag, par_ok, par_err,
                     (last_in == 4'h2), (last_in != 4'h2));
        end
`endif
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drain: out_valid got %b want 0", tag, out_valid); end
`ifdef DESCR_PARITY_CHK_EN
        n_checks++;
        if ({par_ok, par_err} !== 2'b00) begin n_fail++; $display("FAIL %s_par_pulse: got %b want 00", tag, {par_ok, par_err}); end
`endif
    endtask

    task automatic test_basic_frame();
        do_reset();
        run_frame(7'h7F, 4'h2, "basic");
    endtask

    task automatic test_zero_seed();
        run_frame(7'h00, 4'h2, "zseed");
        run_frame(7'h00, 4'h3, "zseed_err");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        pulse_start(7'h7F);
        out_ready = 1'b0;
        push(4'h5, 1'b0, "bp");
        in_valid = 1'b1;
        in_data  = 4'h5;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", c, in_ready); end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 4'h5) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=5", c, out_valid, out_data);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        push(4'h5, 1'b0, "bp2");
        n_checks++;
        if (out_data !== 4'h7) begin n_fail++; $display("FAIL bp_second: got %h want 7", out_data); end
        push(4'h2, 1'b1, "bp3");
        n_checks++;
        if (out_data !== 4'h2 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_third: got d=%h l=%b want d=2 l=1", out_data, out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_restart();
        out_ready = 1'b1;
        pulse_start(7'h7F);
        push(4'h5, 1'b0, "rs");
        start    = 1'b1;
        seed     = 7'h7F;
        in_valid = 1'b1;
        in_data  = 4'h5;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rs_priority: in_ready got %b want 0", in_ready); end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rs_no_accept: out_valid got %b want 0", out_valid); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rs_busy: got %b want 1", busy); end
        push(4'h5, 1'b0, "rs2");
        n_checks++;
        if (out_data !== 4'h5) begin n_fail++; $display("FAIL rs_restarted: got %h want 5", out_data); end
        push(4'h5, 1'b1, "rs3");
        n_checks++;
        if (out_data !== 4'h7 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_close: got d=%h l=%b want d=7 l=1", out_data, out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        pulse_start(7'h7F);
        out_ready = 1'b0;
        push(4'h5, 1'b0, "rm");
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pending: out_valid got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_clear: got v=%b busy=%b want 0 0", out_valid, busy);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'h5;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_no_start: in_ready got %b want 0", in_ready); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_accept: out_valid got %b want 0", out_valid); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_zero_seed();
        test_backpressure();
        test_restart();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_descrambler.md
# nibble_descrambler

Receive-side counterpart of the team's XOR-based nibble scrambler: accepts a stream of 4-bit scrambled nibbles over a valid/ready handshake and XORs each with a self-synchronised-by-seed additive LFSR keystream to recover the plaintext nibble. Sits between the link/deserialiser stage and downstream nibble consumers. It is framed: a `start` pulse loads the seed and opens a frame, and `in_last` closes it.

## Interface
- `SEED_DEFAULT`, 7'h7F, seed loaded when `seed` input is 7'h00 (the all-zero LFSR state is illegal)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle pulse: load LFSR from `seed`, open frame
- `seed`  input  7  LFSR seed, sampled only when `start`=1
- `in_valid`  input  1  scrambled nibble present
- `in_ready`  output  1  block accepts nibble this cycle
- `in_data`  input  4  scrambled nibble
- `in_last`  input  1  marks final nibble of frame
- `out_valid`  output  1  descrambled nibble present
- `out_ready`  input  1  consumer accepts nibble
- `out_data`  output  4  descrambled nibble
- `out_last`  output  1  accompanies final nibble of frame
- `busy`  output  1  high while in RUN state
- `par_ok`, `par_err`  output  1 each  frame check result pulses (only with `DESCR_PARITY_CHK_EN`)

## Operation
- The LFSR is 7 bits, `s[6:0]`, with polynomial x^7+x^6+1. One step: `fb = s[6]^s[5]`, then `s <= {s[5:0], fb}`.
- The keystream bit of each step is `fb`. Four steps are taken per accepted nibble, producing `k[3]` (first) down to `k[0]` (fourth).
- `out_data <= in_data ^ k` and the LFSR advances 4 steps only on input handshake (`in_valid && in_ready`). It never advances otherwise.
- State machine:
  - IDLE: waiting for a frame.
  - IDLE→RUN on `start`.
  - RUN→IDLE on accepted nibble with `in_last`=1.
  - `start` in RUN re-seeds and stays in RUN (frame restart). Any pending output nibble is kept.
- `in_ready = (state==RUN) && (!out_valid || out_ready)`. This is a single output register with no skid buffer.
- `start` and `in_valid` in the same cycle: `start` wins. There is no accept that cycle, and the seed is loaded.
- A `seed` value of 7'h00 loads `SEED_DEFAULT`.
- `out_valid` and `out_data` are held stable until `out_ready`. `out_last` is registered alongside `out_data`.

## Timing
- Reset values:
  - state IDLE, LFSR = `SEED_DEFAULT`
  - `out_valid`=0, `out_data`=0, `out_last`=0
  - `in_ready`=0, `busy`=0
  - `par_ok`=`par_err`=0
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 nibble/cycle while `out_ready`=1.
- `busy` rises the cycle after `start` and falls the cycle after the `in_last` accept.
- Reset mid-frame: all state clears immediately and the pending output is dropped.

## Configuration
- `DESCR_PARITY_CHK_EN` defined:
  - A 4-bit running XOR accumulates the descrambled nibbles of the frame, excluding the last nibble. It is cleared on `start`.
  - The descrambled last nibble is compared with the accumulator. `par_ok` or `par_err` pulses for one cycle, coincident with `out_valid` rising for the `out_last` nibble.
  - The last nibble is still forwarded.
- Undefined: no accumulator, and the `par_ok`/`par_err` ports are absent.

## Test plan
- Basic frame:
  - Stimulus: reset, `start` with seed 7'h7F, then inputs 0x5, 0x5, 0x2 (last), with `out_ready`=1.
  - Response: outputs 0x5, 0x7, 0x2, with `out_last` on the third; keystream nibbles are 0x0, 0x2, 0x0.
- Zero seed:
  - Stimulus: `start` with seed 7'h00.
  - Response: identical outputs to the 7'h7F case.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 3 cycles after the first accept.
  - Response: `in_ready`=0, `out_data` stable at 0x5, and the LFSR does not advance; after release, the second output is still 0x7.
- Restart and priority:
  - Stimulus: `start` mid-frame after one nibble, with `in_valid`=1 in the same cycle.
  - Response: no accept that cycle; the next nibble 0x5 yields 0x5 (keystream restarted).
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 while `out_valid`=1.
  - Response: `out_valid`=0 and `busy`=0 immediately; a subsequent `in_valid` without `start` is not accepted.
- With `DESCR_PARITY_CHK_EN`:
  - Stimulus: the basic frame.
  - Response: `par_ok` pulses; with the last input at 0x3 instead, `par_err` pulses.
